// File: rtl/vtg_pkg.sv
// vtg_pkg: shared XGA (1024x768@60) raster constants, counter widths and colour-bar table.
// Latency: n/a (constants and a pure lookup function only).
// Backpressure: n/a.
package vtg_pkg;

  // Counter widths: the line total must stay below 2**H_CNT_W and the frame total below 2**V_CNT_W.
  localparam int H_CNT_W = 11;
  localparam int V_CNT_W = 10;

  // Horizontal timing in pixels.
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;  // 1344

  // Vertical timing in lines.
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;  // 806

  // Colour bars, left to right, 128 pixels each: {R,G,B}.
  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF,  // white
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'h00FF00,  // green
    24'hFF00FF,  // magenta
    24'hFF0000,  // red
    24'h0000FF,  // blue
    24'h000000   // black
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction

endpackage

// File: rtl/vtg_bar_pattern.sv
// vtg_bar_pattern: maps a bar index (column bits [9:7]) and data-enable to an {R,G,B} colour.
// Latency: combinational; the caller registers the result alongside de.
// Backpressure: none.
// Ports: i_bar - bar index (pixel column / 128), i_de - active area flag, o_rgb - colour, black when i_de=0.
// Built only when VTG_TEST_PATTERN_EN is defined.
`ifdef VTG_TEST_PATTERN_EN
module vtg_bar_pattern
  import vtg_pkg::*;
(
  input  logic [2:0]  i_bar,
  input  logic        i_de,
  output logic [23:0] o_rgb
);

  assign o_rgb = i_de ? bar_colour(i_bar) : 24'h000000;

endmodule
`endif

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (hsync/vsync/de, x/y, line/frame strobes), gated by PLL lock.
// Latency: 1 clk from counter value to all outputs; 2 clk synchronizer delay from pll_locked to counting.
// Backpressure: none, free-running at the pixel clock while locked.
// Ports: clk/rst_n - pixel clock and async active-low reset; pll_locked - async lock input;
//        hsync/vsync - syncs (polarity HS_POL/VS_POL); de - active area; x/y - pixel coordinates;
//        line_start/frame_start - one-cycle strobes; rgb - colour bars, present only with VTG_TEST_PATTERN_EN.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [H_CNT_W-1:0] x,
  output logic [V_CNT_W-1:0] y,
  output logic               line_start,
  output logic               frame_start
`ifdef VTG_TEST_PATTERN_EN
  ,
  output logic [23:0]        rgb
`endif
);

  // Decode boundaries, pre-sized to counter width so every compare is unsigned at that width.
  localparam logic [H_CNT_W-1:0] L_H_ACTIVE = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] L_HS_START = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] L_HS_END   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_CNT_W-1:0] L_H_LAST   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [V_CNT_W-1:0] L_V_ACTIVE = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] L_VS_START = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] L_VS_END   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_CNT_W-1:0] L_V_LAST   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // Two-flop synchronizer for the PLL lock, which is asynchronous to clk.
  logic r_lock_meta;
  logic r_lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Raster counters; held at (0,0) whenever lock is not asserted so relock restarts at the frame origin.
  logic [H_CNT_W-1:0] r_h_cnt;
  logic [V_CNT_W-1:0] r_v_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!r_lock_s) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == L_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == L_V_LAST) ? '0 : r_v_cnt + V_CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + H_CNT_W'(1);
    end
  end

  // Combinational decode of the current counter position.
  logic w_h_zero;
  logic w_de;
  logic w_hs_act;
  logic w_vs_act;
  logic w_line_start;
  logic w_frame_start;

  assign w_h_zero      = (r_h_cnt == '0);
  assign w_de          = (r_h_cnt < L_H_ACTIVE) && (r_v_cnt < L_V_ACTIVE);
  assign w_hs_act      = (r_h_cnt >= L_HS_START) && (r_h_cnt < L_HS_END);
  // Whole-line vsync: v_cnt only changes at h_cnt wrap, so the edges land on h_cnt=0.
  assign w_vs_act      = (r_v_cnt >= L_VS_START) && (r_v_cnt < L_VS_END);
  assign w_line_start  = w_h_zero && (r_v_cnt < L_V_ACTIVE);
  assign w_frame_start = w_h_zero && (r_v_cnt == '0);

  // Single output register stage so every output moves on the same edge.
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic [H_CNT_W-1:0] r_x;
  logic [V_CNT_W-1:0] r_y;
  logic               r_line_start;
  logic               r_frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!r_lock_s) begin
      // Loss of lock drops any sync pulse in progress rather than letting it run on.
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_de          <= w_de;
      r_x           <= r_h_cnt;
      r_y           <= r_v_cnt;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VTG_TEST_PATTERN_EN
  // Bar index is column / 128; the pattern block blanks to black outside the active area.
  logic [23:0] w_rgb;
  logic [23:0] r_rgb;

  vtg_bar_pattern u_bar_pattern (
    .i_bar (r_h_cnt[9:7]),
    .i_de  (w_de),
    .o_rgb (w_rgb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb <= 24'h000000;
    end else if (!r_lock_s) begin
      r_rgb <= 24'h000000;
    end else begin
      r_rgb <= w_rgb;
    end
  end

  assign rgb = r_rgb;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: self-checking bench for video_timing_gen with a reduced frame height.
// Latency: n/a.
// Backpressure: n/a.
module tb_video_timing_gen;

  // Real XGA horizontal timing; short frame so full-frame checks stay cheap.
  localparam int HA = 1024;
  localparam int HF = 24;
  localparam int HSW = 136;
  localparam int HB = 160;
  localparam int VA = 6;
  localparam int VF = 3;
  localparam int VSW = 6;
  localparam int VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  // {hsync, vsync, de, line_start, frame_start, x, y, rgb}
  localparam logic [49:0] IDLE_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 24'd0};
  localparam logic [25:0] IDLE_26  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 10'd0};

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [10:0] x;
  logic [9:0]  y;
  logic        line_start;
  logic        frame_start;
  logic [23:0] obs_rgb;
`ifdef VTG_TEST_PATTERN_EN
  logic [23:0] rgb;
  assign obs_rgb = rgb;
`else
  assign obs_rgb = 24'd0;
`endif

  int n_checks = 0;
  int n_fail = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef VTG_TEST_PATTERN_EN
    ,
    .rgb         (rgb)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: position = cycles elapsed since counting began, raster rules applied arithmetically.
  function automatic logic [49:0] model_out(input int p);
    int h;
    int v;
    logic d;
    logic hs;
    logic vs;
    logic [23:0] c;
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    h = p % HT;
    v = (p / HT) % VT;
    d = (h < HA) && (v < VA);
    hs = !((h >= HA + HF) && (h < HA + HF + HSW));
    vs = !((v >= VA + VF) && (v < VA + VF + VSW));
`ifdef VTG_TEST_PATTERN_EN
    c = d ? bars[(h / 128) % 8] : 24'd0;
`else
    c = 24'd0;
`endif
    return {hs, vs, d, (h == 0) && (v < VA), (h == 0) && (v == 0), 11'(h), 10'(v), c};
  endfunction

  logic        m_s1;
  logic        m_s2;
  int          m_run;
  logic [49:0] exp_vec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1    <= 1'b0;
      m_s2    <= 1'b0;
      m_run   <= 0;
      exp_vec <= IDLE_VEC;
    end else begin
      m_s1 <= pll_locked;
      m_s2 <= m_s1;
      if (m_s2) begin
        exp_vec <= model_out(m_run);
        m_run   <= m_run + 1;
      end else begin
        exp_vec <= IDLE_VEC;
        m_run   <= 0;
      end
    end
  end

  // Scoreboard: every cycle compares the full output vector with the model; tasks inspect the tally.
  logic        sb_en = 1'b0;
  int          sb_err = 0;
  int          sb_cyc = 0;
  int          sb_last_cyc = 0;
  logic [49:0] sb_last_obs = '0;
  logic [49:0] sb_last_exp = '0;
  logic [49:0] obs_vec;

  assign obs_vec = {hsync, vsync, de, line_start, frame_start, x, y, obs_rgb};

  always @(negedge clk) begin
    if (sb_en) begin
      sb_cyc <= sb_cyc + 1;
      if (obs_vec !== exp_vec) begin
        sb_err      <= sb_err + 1;
        sb_last_cyc <= sb_cyc;
        sb_last_obs <= obs_vec;
        sb_last_exp <= exp_vec;
      end
    end
  end

  task automatic test_reset();
    int base;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({hsync, vsync, de, line_start, frame_start, x, y} !== IDLE_26) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", {hsync, vsync, de, line_start, frame_start, x, y}, IDLE_26);
    end
    rst_n = 1'b1;
    sb_en = 1'b1;
    @(posedge clk);
    base = sb_err;
    repeat (100) @(negedge clk);
    n_checks++;
    if (hsync !== 1'b1 || vsync !== 1'b1) begin
      n_fail++;
      $display("FAIL unlocked_sync: got hsync=%b vsync=%b want 1 1", hsync, vsync);
    end
    n_checks++;
    if (de !== 1'b0 || x !== 11'd0 || y !== 10'd0) begin
      n_fail++;
      $display("FAIL unlocked_counters: got de=%b x=%0d y=%0d want 0 0 0", de, x, y);
    end
    @(posedge clk);
    n_checks++;
    if (sb_err != base) begin
      n_fail++;
      $display("FAIL model_unlocked: %0d bad cycles, last cyc %0d got %h want %h",
               sb_err - base, sb_last_cyc, sb_last_obs, sb_last_exp);
    end
  endtask

  task automatic test_lock_start();
    int base;
    int t;
    int c;
    bit found;
    bit prev_de;
    bit prev_hs;
    bit prev_vs;
    int de_rise;
    int de_min;
    int de_max;
    int last_de_fall;
    int gap_min;
    int gap_max;
    int hs_fall;
    int hs_min;
    int hs_max;
    int vs_fall;
    int vs_len;
    int vs_fx;
    int vs_fy;
    int ls_cnt;
    int last_ls;
    int ls_min;
    int ls_max;
    int de_vbl;
    @(posedge clk);
    base = sb_err;
    @(negedge clk);
    pll_locked = 1'b1;
    t = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      t++;
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found || t != 3) begin
      n_fail++;
      $display("FAIL lock_to_frame_start: got %0d clk (seen=%0b) want 3", t, found);
    end
    n_checks++;
    if ({x, y, de} !== {11'd0, 10'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL first_pixel: got x=%0d y=%0d de=%b want 0 0 1", x, y, de);
    end

    prev_de = de; prev_hs = hsync; prev_vs = vsync;
    de_rise = 0; de_min = 1 << 30; de_max = 0; last_de_fall = -1;
    gap_min = 1 << 30; gap_max = 0; hs_fall = -1; hs_min = 1 << 30; hs_max = 0;
    vs_fall = -1; vs_len = -1; vs_fx = -1; vs_fy = -1;
    ls_cnt = (line_start === 1'b1) ? 1 : 0; last_ls = 0; ls_min = 1 << 30; ls_max = 0;
    de_vbl = 0; found = 1'b0;
    for (c = 1; c <= FRAME + 10; c++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      if (de && !prev_de) de_rise = c;
      if (!de && prev_de) begin
        if (c - de_rise < de_min) de_min = c - de_rise;
        if (c - de_rise > de_max) de_max = c - de_rise;
        last_de_fall = c;
      end
      if (!hsync && prev_hs) begin
        hs_fall = c;
        if (last_de_fall >= 0) begin
          if (c - last_de_fall < gap_min) gap_min = c - last_de_fall;
          if (c - last_de_fall > gap_max) gap_max = c - last_de_fall;
          last_de_fall = -1;
        end
      end
      if (hsync && !prev_hs && hs_fall >= 0) begin
        if (c - hs_fall < hs_min) hs_min = c - hs_fall;
        if (c - hs_fall > hs_max) hs_max = c - hs_fall;
      end
      if (!vsync && prev_vs) begin
        vs_fall = c; vs_fx = int'(x); vs_fy = int'(y);
      end
      if (vsync && !prev_vs && vs_fall >= 0) vs_len = c - vs_fall;
      if (line_start === 1'b1) begin
        ls_cnt++;
        if (c - last_ls < ls_min) ls_min = c - last_ls;
        if (c - last_ls > ls_max) ls_max = c - last_ls;
        last_ls = c;
      end
      if (de && int'(y) >= VA) de_vbl++;
      prev_de = de; prev_hs = hsync; prev_vs = vsync;
    end
    n_checks++;
    if (!found || c != FRAME) begin
      n_fail++;
      $display("FAIL frame_period: got %0d clk (seen=%0b) want %0d", c, found, FRAME);
    end
    n_checks++;
    if (de_min != HA || de_max != HA) begin
      n_fail++;
      $display("FAIL de_width: got min %0d max %0d want %0d", de_min, de_max, HA);
    end
    n_checks++;
    if (gap_min != HF || gap_max != HF) begin
      n_fail++;
      $display("FAIL de_to_hsync: got min %0d max %0d want %0d", gap_min, gap_max, HF);
    end
    n_checks++;
    if (hs_min != HSW || hs_max != HSW) begin
      n_fail++;
      $display("FAIL hsync_width: got min %0d max %0d want %0d", hs_min, hs_max, HSW);
    end
    n_checks++;
    if (ls_min != HT || ls_max != HT) begin
      n_fail++;
      $display("FAIL line_period: got min %0d max %0d want %0d", ls_min, ls_max, HT);
    end
    n_checks++;
    if (ls_cnt != VA) begin
      n_fail++;
      $display("FAIL line_start_count: got %0d want %0d", ls_cnt, VA);
    end
    n_checks++;
    if (vs_fy != VA + VF || vs_fx != 0) begin
      n_fail++;
      $display("FAIL vsync_start: got x=%0d y=%0d want x=0 y=%0d", vs_fx, vs_fy, VA + VF);
    end
    n_checks++;
    if (vs_len != VSW * HT) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d want %0d", vs_len, VSW * HT);
    end
    n_checks++;
    if (de_vbl != 0) begin
      n_fail++;
      $display("FAIL de_in_vblank: got %0d cycles want 0", de_vbl);
    end
    @(posedge clk);
    n_checks++;
    if (sb_err != base) begin
      n_fail++;
      $display("FAIL model_frame: %0d bad cycles, last cyc %0d got %h want %h",
               sb_err - base, sb_last_cyc, sb_last_obs, sb_last_exp);
    end
  endtask

  task automatic test_lock_loss();
    int base;
    int tx;
    int ty;
    int hold;
    int t;
    bit found;
    for (int it = 0; it < 2; it++) begin
      if (it == 0) begin
        tx = $urandom_range(HT - 3, 1);
        ty = $urandom_range(VA - 1, 0);
      end else begin
        // Inside both sync pulses, to show neither is stretched.
        tx = $urandom_range(HA + HF + HSW - 3, HA + HF);
        ty = VA + VF;
      end
      @(posedge clk);
      base = sb_err;
      found = 1'b0;
      for (int c = 0; c < FRAME + 10; c++) begin
        @(negedge clk);
        if (x == 11'(tx) && y == 10'(ty)) begin
          found = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!found) begin
        n_fail++;
        $display("FAIL lock_loss_reach: got no visit to x=%0d y=%0d want one", tx, ty);
      end
      pll_locked = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({x, y} !== {11'(tx + 2), 10'(ty)}) begin
        n_fail++;
        $display("FAIL lock_loss_sync_delay: got x=%0d y=%0d want x=%0d y=%0d", x, y, tx + 2, ty);
      end
      @(negedge clk);
      n_checks++;
      if ({hsync, vsync, de, line_start, frame_start, x, y} !== IDLE_26) begin
        n_fail++;
        $display("FAIL lock_loss_idle: got %h want %h", {hsync, vsync, de, line_start, frame_start, x, y}, IDLE_26);
      end
      hold = $urandom_range(40, 5);
      repeat (hold) @(negedge clk);
      pll_locked = 1'b1;
      t = 0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        t++;
        if (frame_start === 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      n_checks++;
      if (!found || t != 3 || x !== 11'd0 || y !== 10'd0) begin
        n_fail++;
        $display("FAIL relock_restart: got %0d clk x=%0d y=%0d want 3 clk x=0 y=0", t, x, y);
      end
      @(posedge clk);
      n_checks++;
      if (sb_err != base) begin
        n_fail++;
        $display("FAIL model_lock_loss: %0d bad cycles, last cyc %0d got %h want %h",
                 sb_err - base, sb_last_cyc, sb_last_obs, sb_last_exp);
      end
    end
  endtask

  task automatic test_random_lock();
    int base;
    int toggles;
    @(posedge clk);
    base = sb_err;
    toggles = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(149, 0) == 0) begin
        pll_locked = ~pll_locked;
        toggles++;
      end
    end
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (sb_err != base) begin
      n_fail++;
      $display("FAIL model_random_lock: %0d bad cycles over %0d toggles, last cyc %0d got %h want %h",
               sb_err - base, toggles, sb_last_cyc, sb_last_obs, sb_last_exp);
    end
  endtask

`ifdef VTG_TEST_PATTERN_EN
  task automatic test_pattern();
    bit found;
    pll_locked = 1'b0;
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (line_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL pattern_line_start: got none within 10 clk want one");
    end
    for (int c = 0; c < HT; c++) begin
      if (c > 0) @(negedge clk);
      case (x)
        11'd0: begin
          n_checks++;
          if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL rgb_x0: got %h want FFFFFF", rgb); end
        end
        11'd127: begin
          n_checks++;
          if (rgb !== 24'hFFFFFF) begin n_fail++; $display("FAIL rgb_x127: got %h want FFFFFF", rgb); end
        end
        11'd128: begin
          n_checks++;
          if (rgb !== 24'hFFFF00) begin n_fail++; $display("FAIL rgb_x128: got %h want FFFF00", rgb); end
        end
        11'd640: begin
          n_checks++;
          if (rgb !== 24'hFF0000) begin n_fail++; $display("FAIL rgb_x640: got %h want FF0000", rgb); end
        end
        11'd1023: begin
          n_checks++;
          if (rgb !== 24'h000000) begin n_fail++; $display("FAIL rgb_x1023: got %h want 000000", rgb); end
        end
        11'd1100: begin
          n_checks++;
          if (rgb !== 24'h000000 || de !== 1'b0) begin
            n_fail++;
            $display("FAIL rgb_blank: got rgb=%h de=%b want 000000 0", rgb, de);
          end
        end
        default: ;
      endcase
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_lock_start();
    test_lock_loss();
    test_random_lock();
`ifdef VTG_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
